// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate unit: default widths,
// the signed data type and its representable limits.
// Optional feature macro: MAC_UNIT_SAT_EN (clamp instead of wrap).
package mac_pkg;

    localparam int DW_DEF   = 64;
    localparam int CNTW_DEF = 16;

    typedef logic signed [DW_DEF-1:0] data_t;

    localparam data_t DATA_MAX = {1'b0, {(DW_DEF-1){1'b1}}};
    localparam data_t DATA_MIN = {1'b1, {(DW_DEF-1){1'b0}}};

endpackage

// File: rtl/mac_sat.sv
// Signed width reduction from IW to OW bits with overflow detection.
// With MAC_UNIT_SAT_EN defined the result clamps to the signed OW-bit
// max/min on overflow; otherwise the low OW bits are kept (two's-complement wrap).
module mac_sat #(
    parameter int IW = 128,
    parameter int OW = 64
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 ovf
);

    logic [IW-OW:0] hi;

    // Value fits in OW bits only if every bit from the OW-bit sign upward agrees
    always_comb begin
        hi  = din[IW-1:OW-1];
        ovf = (hi != '0) && (hi != '1);
`ifdef MAC_UNIT_SAT_EN
        if (ovf)
            dout = din[IW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        else
            dout = din[OW-1:0];
`else
        dout = din[OW-1:0];
`endif
    end

endmodule

// File: rtl/mac_unit.sv
// Two-stage systolic multiply-accumulate cell.
// Stage 1 registers the operand pass-through and the reduced product;
// stage 2 adds the product into the accumulator, counts accumulates and
// keeps a sticky overflow flag. Optional macro: MAC_UNIT_SAT_EN selects
// clamping instead of wrapping for both the product and the sum.
module mac_unit
    import mac_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 WrEn,
    input  logic signed [DW-1:0] Ain,
    input  logic signed [DW-1:0] Bin,
    input  logic signed [DW-1:0] Cin,
    output logic signed [DW-1:0] Aout,
    output logic signed [DW-1:0] Bout,
    output logic signed [DW-1:0] Cout,
    output logic                 ovf,
    output logic [CNTW-1:0]      mac_cnt
);

    logic signed [2*DW-1:0] prod_full;
    logic signed [DW-1:0]   prod_red;
    logic                   prod_red_ovf;

    logic signed [DW-1:0]   prod;
    logic                   prod_ovf;
    logic                   vld;

    logic signed [DW:0]     sum_full;
    logic signed [DW-1:0]   sum_red;
    logic                   sum_ovf;

    logic signed [DW-1:0]   acc;

    // Full-precision product before reduction to DW bits
    always_comb begin
        prod_full = Ain * Bin;
    end

    mac_sat #(
        .IW (2*DW),
        .OW (DW)
    ) u_prod_sat (
        .din  (prod_full),
        .dout (prod_red),
        .ovf  (prod_red_ovf)
    );

    // One guard bit is enough to see any overflow of a two-operand sum
    always_comb begin
        sum_full = {acc[DW-1], acc} + {prod[DW-1], prod};
    end

    mac_sat #(
        .IW (DW+1),
        .OW (DW)
    ) u_sum_sat (
        .din  (sum_full),
        .dout (sum_red),
        .ovf  (sum_ovf)
    );

    // Stage 1: capture operands and product when enabled; vld marks a fresh product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Aout     <= '0;
            Bout     <= '0;
            prod     <= '0;
            prod_ovf <= 1'b0;
            vld      <= 1'b0;
        end else begin
            vld <= en;
            if (en) begin
                Aout     <= Ain;
                Bout     <= Bin;
                prod     <= prod_red;
                prod_ovf <= prod_red_ovf;
            end
        end
    end

    // Stage 2: preload has priority over accumulate; counter saturates at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            ovf     <= 1'b0;
            mac_cnt <= '0;
        end else if (WrEn) begin
            acc     <= Cin;
            ovf     <= 1'b0;
            mac_cnt <= '0;
        end else if (vld) begin
            acc <= sum_red;
            ovf <= ovf | prod_ovf | sum_ovf;
            if (mac_cnt != '1)
                mac_cnt <= mac_cnt + 1'b1;
        end
    end

    assign Cout = acc;

endmodule

// File: tb/tb_mac_unit.sv
// Scoreboard bench for mac_unit: the stimulus process drives one cycle at a
// time on the falling edge and queues the state expected after the next
// rising edge; the monitor pops and compares just after each rising edge.
module tb_mac_unit;
    import mac_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        WrEn = 1'b0;
    data_t       Ain = '0, Bin = '0, Cin = '0;
    data_t       Aout, Bout, Cout;
    logic        ovf;
    logic [15:0] mac_cnt;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic        chk_ab;
        data_t       a;
        data_t       b;
        data_t       c;
        logic [15:0] cnt;
        logic        ov;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mac_unit #(.DW(64), .CNTW(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .WrEn    (WrEn),
        .Ain     (Ain),
        .Bin     (Bin),
        .Cin     (Cin),
        .Aout    (Aout),
        .Bout    (Bout),
        .Cout    (Cout),
        .ovf     (ovf),
        .mac_cnt (mac_cnt)
    );

`ifdef MAC_UNIT_SAT_EN
    localparam data_t OVF_POS  = DATA_MAX;
    localparam data_t OVF_NEG  = DATA_MIN;
    localparam data_t PROD_BIG = DATA_MAX;
`else
    localparam data_t OVF_POS  = DATA_MIN;
    localparam data_t OVF_NEG  = DATA_MAX;
    localparam data_t PROD_BIG = 64'sd0;
`endif

    localparam data_t BIG = 64'sh0000_0100_0000_0000; // 2^40

    // Drive one cycle and queue the expected post-edge state
    task automatic cyc(input string name, input logic r, input logic e,
                       input logic w, input data_t a, input data_t b,
                       input data_t c, input logic chk_ab,
                       input data_t ea, input data_t eb, input data_t ec,
                       input logic [15:0] ecnt, input logic eov);
        exp_t x;
        @(negedge clk);
        rst  = r;
        en   = e;
        WrEn = w;
        Ain  = a;
        Bin  = b;
        Cin  = c;
        x.name = name; x.chk_ab = chk_ab; x.a = ea; x.b = eb;
        x.c = ec; x.cnt = ecnt; x.ov = eov;
        sb.push_back(x);
    endtask

    task automatic cmp(input string name, input string f, input data_t got, input data_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s.%s: got %0d, want %0d", name, f, got, want);
        end
    endtask

    // Monitor: compare every queued expectation right after its edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                if (x.chk_ab) begin
                    cmp(x.name, "Aout", Aout, x.a);
                    cmp(x.name, "Bout", Bout, x.b);
                end
                cmp(x.name, "Cout", Cout, x.c);
                cmp(x.name, "mac_cnt", data_t'(mac_cnt), data_t'(x.cnt));
                cmp(x.name, "ovf", data_t'(ovf), data_t'(x.ov));
            end
        end
    end

    initial begin
        // Reset held with live inputs: everything stays zero
        for (int unsigned i = 0; i < 3; i++)
            cyc("reset", 1, 1, 0, 5, 7, 0, 1, 0, 0, 0, 0, 0);
        cyc("release_load0", 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // Stream: 1 - 16 + 9 + 16457 = 16451
        cyc("s1", 0, 1, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0);
        cyc("s2", 0, 1, 0, -8, 2, 0, 1, -8, 2, 1, 1, 0);
        cyc("s3", 0, 1, 0, 3, 3, 0, 1, 3, 3, -15, 2, 0);
        cyc("s4", 0, 1, 0, 16457, 1, 0, 1, 16457, 1, -6, 3, 0);
        cyc("s5", 0, 0, 0, 99, 99, 0, 1, 16457, 1, 16451, 4, 0);

        // Hold with en low
        for (int unsigned i = 0; i < 3; i++)
            cyc("hold", 0, 0, 0, 77, 55, 0, 1, 16457, 1, 16451, 4, 0);

        // Preload wins over an in-flight product of 6
        cyc("pri_issue", 0, 1, 0, 2, 3, 0, 1, 2, 3, 16451, 4, 0);
        cyc("pri_load", 0, 0, 1, 0, 0, 100, 1, 2, 3, 100, 0, 0);
        cyc("pri_after", 0, 0, 0, 0, 0, 0, 1, 2, 3, 100, 0, 0);

        // Sum overflow upward
        cyc("ov_load", 0, 0, 1, 0, 0, DATA_MAX, 0, 0, 0, DATA_MAX, 0, 0);
        cyc("ov_issue", 0, 1, 0, 1, 1, 0, 1, 1, 1, DATA_MAX, 0, 0);
        cyc("ov_acc", 0, 0, 0, 0, 0, 0, 0, 0, 0, OVF_POS, 1, 1);
        cyc("ov_sticky", 0, 0, 0, 0, 0, 0, 0, 0, 0, OVF_POS, 1, 1);
        cyc("ov_clear", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Sum overflow downward
        cyc("un_load", 0, 0, 1, 0, 0, DATA_MIN, 0, 0, 0, DATA_MIN, 0, 0);
        cyc("un_issue", 0, 1, 0, -1, 1, 0, 1, -1, 1, DATA_MIN, 0, 0);
        cyc("un_acc", 0, 0, 0, 0, 0, 0, 0, 0, 0, OVF_NEG, 1, 1);
        cyc("un_clear", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Product reduction overflow: 2^40 * 2^40 = 2^80
        cyc("pov_issue", 0, 1, 0, BIG, BIG, 0, 1, BIG, BIG, 0, 0, 0);
        cyc("pov_acc", 0, 0, 0, 0, 0, 0, 0, 0, 0, PROD_BIG, 1, 1);
        cyc("pov_clear", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Mid-run reset discards the in-flight product
        cyc("mr_issue", 0, 1, 0, 5, 5, 0, 1, 5, 5, 0, 0, 0);
        cyc("mr_rst", 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc("mr_idle", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc("mr_issue2", 0, 1, 0, 2, 3, 0, 1, 2, 3, 0, 0, 0);
        cyc("mr_acc", 0, 0, 0, 0, 0, 0, 1, 2, 3, 6, 1, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int unsigned i = 0; i < 10 && sb.size() != 0; i++)
            @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, want completion");
        $fatal(1);
    end

endmodule
